// File: rtl/pkt_ser_pkg.sv
// Shared types and width helpers for the packet serializer and its sample FIFO.
package pkt_ser_pkg;

    // Serializer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } ser_state_t;

    localparam int WIDTH_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    // FIFO pointers carry one extra wrap bit above the address.
    function automatic int calc_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Bit counter spans both slots of a frame.
    function automatic int calc_bitcnt_w(input int width);
        return $clog2(2 * width);
    endfunction

    localparam int PTR_W    = calc_ptr_w(FIFO_DEPTH_DEF);
    localparam int BITCNT_W = calc_bitcnt_w(WIDTH_DEF);

    typedef logic [WIDTH_DEF-1:0] sample_t;

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers; read data is the current head.
module pkt_fifo
    import pkt_ser_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = calc_ptr_w(FIFO_DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_nxt_s;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic             full_r;

    // Next pointer values, used both for the pointer registers and the full flag.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_i) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_i) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Pointer and full-flag registers; full reflects occupancy after this edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            full_r   <= (wr_ptr_nxt_s[PW-1] != rd_ptr_nxt_s[PW-1]) &&
                        (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
        end
    end

    // Sample storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_r[rd_ptr_r[AW-1:0]];
    assign full_o  = full_r;
    assign empty_o = (wr_ptr_r == rd_ptr_r);

endmodule

// File: rtl/pkt_serializer.sv
// Packet serializer: buffers mono samples and streams them as left-justified
// stereo (same sample in both slots) on sclk/lrclk/sdata.
// Build option PKT_SER_STICKY_ERR_EN: overflow/underflow flags latch until reset
// instead of pulsing once per event.
module pkt_serializer
    import pkt_ser_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] pkt_i,
    input  logic             pktValid_i,
    output logic             sclk_o,
    output logic             lrclk_o,
    output logic             sdata_o,
    output logic             fifoFull_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int BCW   = calc_bitcnt_w(WIDTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BCW-1:0]   SLOT_LAST  = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0]   FRAME_LAST = BCW'(2 * WIDTH - 1);

    ser_state_t       state_r;
    ser_state_t       state_nxt_s;
    logic [DIV_W-1:0] div_r;
    logic [BCW-1:0]   bit_cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] hold_r;
    logic             sclk_r;
    logic             lrclk_r;
    logic             sdata_r;
    logic             overflow_r;
    logic             underflow_r;

    logic [WIDTH-1:0] head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;
    logic             load_s;
    logic             tick_s;
    logic             frame_end_s;
    logic             overflow_evt_s;
    logic             underflow_evt_s;

    pkt_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (pkt_i),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, FIFO pop/push decisions and error events.
    always_comb begin
        state_nxt_s     = state_r;
        pop_s           = 1'b0;
        load_s          = 1'b0;
        underflow_evt_s = 1'b0;
        tick_s          = (div_r == DIV_LAST);
        frame_end_s     = tick_s && sclk_r && (bit_cnt_r == FRAME_LAST);
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                pop_s       = 1'b1;
                load_s      = 1'b1;
                state_nxt_s = SHIFT;
            end
            SHIFT: begin
                if (frame_end_s) begin
                    if (!fifo_empty_s) begin
                        // Back-to-back frame: next sample loads on this same falling edge.
                        pop_s       = 1'b1;
                        load_s      = 1'b1;
                        state_nxt_s = SHIFT;
                    end else begin
                        underflow_evt_s = 1'b1;
                        state_nxt_s     = IDLE;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        // A full FIFO still accepts a write when a pop frees a slot this cycle.
        push_s         = pktValid_i && (!fifo_full_s || pop_s);
        overflow_evt_s = pktValid_i && fifo_full_s && !pop_s;
    end

    // Serial datapath: divider, bit clock, bit counter and shift register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_r     <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            hold_r    <= '0;
            sclk_r    <= 1'b0;
            lrclk_r   <= 1'b0;
            sdata_r   <= 1'b0;
        end else if (load_s) begin
            shift_r   <= head_s;
            hold_r    <= head_s;
            sdata_r   <= head_s[WIDTH-1];
            lrclk_r   <= 1'b0;
            sclk_r    <= 1'b0;
            div_r     <= '0;
            bit_cnt_r <= '0;
        end else if (state_r == SHIFT) begin
            if (tick_s) begin
                div_r  <= '0;
                sclk_r <= ~sclk_r;
                if (sclk_r) begin
                    if (bit_cnt_r == FRAME_LAST) begin
                        // Frame over with nothing queued: stream stops low.
                        sdata_r   <= 1'b0;
                        lrclk_r   <= 1'b0;
                        bit_cnt_r <= '0;
                    end else if (bit_cnt_r == SLOT_LAST) begin
                        // Replay the held sample in the right slot.
                        shift_r   <= hold_r;
                        sdata_r   <= hold_r[WIDTH-1];
                        lrclk_r   <= 1'b1;
                        bit_cnt_r <= bit_cnt_r + BCW'(1);
                    end else begin
                        shift_r   <= {shift_r[WIDTH-2:0], 1'b0};
                        sdata_r   <= shift_r[WIDTH-2];
                        bit_cnt_r <= bit_cnt_r + BCW'(1);
                    end
                end
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end else begin
            div_r   <= '0;
            sclk_r  <= 1'b0;
            lrclk_r <= 1'b0;
            sdata_r <= 1'b0;
        end
    end

    // Error flags: sticky or single-cycle pulses depending on build.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
`ifdef PKT_SER_STICKY_ERR_EN
            overflow_r  <= overflow_r  | overflow_evt_s;
            underflow_r <= underflow_r | underflow_evt_s;
`else
            overflow_r  <= overflow_evt_s;
            underflow_r <= underflow_evt_s;
`endif
        end
    end

    assign sclk_o      = sclk_r;
    assign lrclk_o     = lrclk_r;
    assign sdata_o     = sdata_r;
    assign fifoFull_o  = fifo_full_s;
    assign overflow_o  = overflow_r;
    assign underflow_o = underflow_r;

endmodule

// File: tb/tb_pkt_serializer.sv
// Testbench for pkt_serializer (WIDTH=16, CLK_DIV=2, FIFO_DEPTH=4).
// The reference model keeps a sample queue and a frame phase counter; expected
// sclk/lrclk/sdata are computed arithmetically from the phase.
module tb_pkt_serializer;

    localparam int W     = 16;
    localparam int D     = 2;
    localparam int DEPTH = 4;
    localparam int FRAME = 4 * W * D;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  pkt;
    logic          pkt_valid;
    logic          sclk, lrclk, sdata, fifo_full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    int           m_mode;   // 0 idle, 1 load pending, 2 streaming
    int           m_phase;  // clk cycles since frame start
    logic [W-1:0] m_cur;
    logic         e_ov;
    logic         e_uf;

    pkt_serializer #(
        .WIDTH      (W),
        .CLK_DIV    (D),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .pkt_i       (pkt),
        .pktValid_i  (pkt_valid),
        .sclk_o      (sclk),
        .lrclk_o     (lrclk),
        .sdata_o     (sdata),
        .fifoFull_o  (fifo_full),
        .overflow_o  (overflow),
        .underflow_o (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_mode  = 0;
        m_phase = 0;
        m_cur   = '0;
        e_ov    = 1'b0;
        e_uf    = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d);
        int   sz;
        logic popped;
        logic ov_ev;
        logic uf_ev;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sz     = mq.size();
        popped = 1'b0;
        ov_ev  = 1'b0;
        uf_ev  = 1'b0;
        if (m_mode == 0) begin
            if (sz > 0) m_mode = 1;
        end else if (m_mode == 1) begin
            m_cur   = mq.pop_front();
            popped  = 1'b1;
            m_mode  = 2;
            m_phase = 0;
        end else begin
            if (m_phase == FRAME - 1) begin
                if (sz > 0) begin
                    m_cur   = mq.pop_front();
                    popped  = 1'b1;
                    m_phase = 0;
                end else begin
                    m_mode = 0;
                    uf_ev  = 1'b1;
                end
            end else begin
                m_phase++;
            end
        end
        if (v) begin
            if (sz < DEPTH || popped) mq.push_back(d);
            else ov_ev = 1'b1;
        end
`ifdef PKT_SER_STICKY_ERR_EN
        e_ov = e_ov | ov_ev;
        e_uf = e_uf | uf_ev;
`else
        e_ov = ov_ev;
        e_uf = uf_ev;
`endif
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0b expected=%0b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        int   idx;
        logic e_sclk, e_lr, e_sd;
        e_sclk = 1'b0;
        e_lr   = 1'b0;
        e_sd   = 1'b0;
        if (m_mode == 2) begin
            idx    = m_phase / (2 * D);
            e_sclk = ((m_phase / D) % 2) == 1;
            e_lr   = (idx >= W);
            e_sd   = m_cur[W - 1 - (idx % W)];
        end
        chk("sclk", sclk, e_sclk);
        chk("lrclk", lrclk, e_lr);
        chk("sdata", sdata, e_sd);
        chk("fifo_full", fifo_full, (mq.size() == DEPTH));
        chk("overflow", overflow, e_ov);
        chk("underflow", underflow, e_uf);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d);
        pkt       = d;
        pkt_valid = v;
        @(posedge clk);
        model_edge(v, d);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
    endtask

    initial begin
        pkt       = '0;
        pkt_valid = 1'b0;
        rst_n     = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;

        // 1: reset held 10 cycles, outputs stay 0
        idle(10);
        rst_n = 1'b1;
        idle(3);

        // 2: single sample, full frame then underflow
        step(1'b1, 16'hA5C3);
        idle(FRAME + 10);

        // 3: two samples 3 cycles apart -> contiguous frames
        step(1'b1, 16'h8000);
        idle(2);
        step(1'b1, 16'h0001);
        idle(2 * FRAME + 10);

        // 4: mid-frame burst of 5 -> 4 accepted, one overflow
        step(1'b1, W'($urandom));
        idle(20);
        for (int i = 1; i <= 5; i++) step(1'b1, W'(i));
        idle(5 * FRAME + 10);

        // 5: async reset at left-slot bit 7
        step(1'b1, W'($urandom));
        idle(1 + 7 * 2 * D + 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        idle(2);
        rst_n = 1'b1;
        idle(2);
        step(1'b1, W'($urandom));
        idle(FRAME + 10);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), W'($urandom));
        end
        idle(5 * FRAME + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
